// File: rtl/demux1ne6_sekuencial.sv
// ============================================================================
//  Module      : demux1ne6_sekuencial
//  Description : Sequential 1-to-6 demultiplexer with a ready/valid accept
//                phase, a stallable write phase and a sticky bad-select flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux1ne6_sekuencial #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Hyrja,
    input  logic [2:0]       S,
    input  logic             Valid,
    input  logic             Ndal,
    output logic             Gati,
    output logic [WIDTH-1:0] Dalja0,
    output logic [WIDTH-1:0] Dalja1,
    output logic [WIDTH-1:0] Dalja2,
    output logic [WIDTH-1:0] Dalja3,
    output logic [WIDTH-1:0] Dalja4,
    output logic [WIDTH-1:0] Dalja5,
    output logic [5:0]       Shkruar,
    output logic             Gabim,
    output logic [3:0]       Numri
);

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        PRANIM = 2'd1,
        SHKRIM = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_data;
    logic [2:0]       r_sel;
    logic [WIDTH-1:0] r_dalja [6];
    logic [5:0]       r_shkruar;
    logic             r_gabim;
    logic [3:0]       r_numri;

    logic             w_write;
    logic             w_bad;
    logic [5:0]       w_onehot;

    // A pending write completes only when not stalled; the select decides
    // whether it lands in a register or raises the error flag.
    assign w_write  = (r_state == SHKRIM) && !Ndal && (r_sel <= 3'd5);
    assign w_bad    = (r_state == SHKRIM) && !Ndal && (r_sel > 3'd5);
    assign w_onehot = 6'b000001 << r_sel;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        Gati         = 1'b0;
        case (r_state)
            INIT: begin
                w_next_state = PRANIM;
            end
            PRANIM: begin
                Gati = 1'b1;
                if (Valid) begin
                    w_next_state = SHKRIM;
                end
            end
            SHKRIM: begin
                if (!Ndal) begin
                    w_next_state = PRANIM;
                end
            end
            default: begin
                w_next_state = INIT;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_data    <= '0;
            r_sel     <= '0;
            r_shkruar <= '0;
            r_gabim   <= 1'b0;
            r_numri   <= '0;
        end else begin
            if ((r_state == PRANIM) && Valid) begin
                r_data <= Hyrja;
                r_sel  <= S;
            end
            r_shkruar <= w_write ? w_onehot : 6'b000000;
            if (w_bad) begin
                r_gabim <= 1'b1;
            end
            if (w_write) begin
                r_numri <= r_numri + 4'd1;
            end
        end
    end

    generate
        for (genvar k = 0; k < 6; k++) begin : g_dalja
            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) begin
                    r_dalja[k] <= '0;
                end else if (w_write && (r_sel == 3'(k))) begin
                    r_dalja[k] <= r_data;
                end
            end
        end
    endgenerate

    assign Dalja0  = r_dalja[0];
    assign Dalja1  = r_dalja[1];
    assign Dalja2  = r_dalja[2];
    assign Dalja3  = r_dalja[3];
    assign Dalja4  = r_dalja[4];
    assign Dalja5  = r_dalja[5];
    assign Shkruar = r_shkruar;
    assign Gabim   = r_gabim;
    assign Numri   = r_numri;

endmodule

`default_nettype wire

// File: tb/tb_demux1ne6_sekuencial.sv
// ============================================================================
//  Module      : tb_demux1ne6_sekuencial
//  Description : Directed self-checking bench for demux1ne6_sekuencial with a
//                request-queue reference model compared every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux1ne6_sekuencial;

    localparam int WIDTH = 16;

    logic             Clock = 1'b0;
    logic             Reset = 1'b0;
    logic [WIDTH-1:0] Hyrja = '0;
    logic [2:0]       S     = '0;
    logic             Valid = 1'b0;
    logic             Ndal  = 1'b0;
    logic             Gati;
    logic [WIDTH-1:0] d0, d1, d2, d3, d4, d5;
    logic [5:0]       Shkruar;
    logic             Gabim;
    logic [3:0]       Numri;
    logic [WIDTH-1:0] dal [6];

    int tests = 0;
    int fails = 0;

    demux1ne6_sekuencial #(.WIDTH(WIDTH)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Hyrja  (Hyrja),
        .S      (S),
        .Valid  (Valid),
        .Ndal   (Ndal),
        .Gati   (Gati),
        .Dalja0 (d0),
        .Dalja1 (d1),
        .Dalja2 (d2),
        .Dalja3 (d3),
        .Dalja4 (d4),
        .Dalja5 (d5),
        .Shkruar(Shkruar),
        .Gabim  (Gabim),
        .Numri  (Numri)
    );

    assign dal[0] = d0;
    assign dal[1] = d1;
    assign dal[2] = d2;
    assign dal[3] = d3;
    assign dal[4] = d4;
    assign dal[5] = d5;

    always #5 Clock = ~Clock;

    // Reference model: a just-reset flag plus a queue holding at most one
    // outstanding request; ready means "out of reset and nothing pending".
    bit               m_init = 1'b1;
    logic [18:0]      m_pend [$];
    logic [18:0]      m_req;
    logic [WIDTH-1:0] m_dal [6] = '{default: '0};
    logic [5:0]       m_shk = '0;
    bit               m_gab = 1'b0;
    int               m_cnt = 0;

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_init = 1'b1;
            m_pend.delete();
            m_dal  = '{default: '0};
            m_shk  = '0;
            m_gab  = 1'b0;
            m_cnt  = 0;
        end else begin
            m_shk = '0;
            if (m_init) begin
                m_init = 1'b0;
            end else if (m_pend.size() == 0) begin
                if (Valid) m_pend.push_back({S, Hyrja});
            end else if (!Ndal) begin
                m_req = m_pend.pop_front();
                if (m_req[18:16] < 3'd6) begin
                    m_dal[m_req[18:16]] = m_req[15:0];
                    m_shk[m_req[18:16]] = 1'b1;
                    m_cnt = (m_cnt + 1) % 16;
                end else begin
                    m_gab = 1'b1;
                end
            end
        end
    end

    always @(negedge Clock) begin
        tests++;
        if (Gati !== (!m_init && m_pend.size() == 0) || Shkruar !== m_shk ||
            Gabim !== m_gab || Numri !== 4'(m_cnt) || dal !== m_dal) begin
            fails++;
            $display("FAIL model t=%0t: Gati=%b Shk=%b Gab=%b Num=%0d D=%h/%h/%h/%h/%h/%h required Gati=%b Shk=%b Gab=%b Num=%0d D=%h/%h/%h/%h/%h/%h",
                     $time, Gati, Shkruar, Gabim, Numri, d0, d1, d2, d3, d4, d5,
                     (!m_init && m_pend.size() == 0), m_shk, m_gab, m_cnt,
                     m_dal[0], m_dal[1], m_dal[2], m_dal[3], m_dal[4], m_dal[5]);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Advance one edge; inputs changed afterwards apply at the next edge.
    task automatic step();
        @(posedge Clock);
        #2;
    endtask

    task automatic do_reset();
        Valid = 1'b0;
        Ndal  = 1'b0;
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        #1;
        chk("rst_gati_low", 32'(Gati), 32'd0);
        step();
        chk("rst_gati_high", 32'(Gati), 32'd1);
    endtask

    initial begin
        #1 Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        #1;
        chk("release_gati0", 32'(Gati), 32'd0);
        chk("release_numri", 32'(Numri), 32'd0);
        chk("release_gabim", 32'(Gabim), 32'd0);
        for (int k = 0; k < 6; k++) chk("release_dalja", 32'(dal[k]), 32'd0);
        step();
        chk("release_gati1", 32'(Gati), 32'd1);

        // basic routing
        Valid = 1'b1; Hyrja = 16'hA5A5; S = 3'd3;
        step();
        chk("basic_busy", 32'(Gati), 32'd0);
        Valid = 1'b0; Hyrja = 16'h0000; S = 3'd0;
        step();
        chk("basic_d3", 32'(d3), 32'hA5A5);
        chk("basic_shk", 32'(Shkruar), 32'b001000);
        chk("basic_num", 32'(Numri), 32'd1);
        chk("basic_d0", 32'(d0), 32'd0);
        step();
        chk("basic_shk_clr", 32'(Shkruar), 32'd0);

        // stall
        Valid = 1'b1; Hyrja = 16'h1234; S = 3'd0; Ndal = 1'b1;
        step();
        Valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_gati", 32'(Gati), 32'd0);
            chk("stall_d0", 32'(d0), 32'd0);
            step();
        end
        chk("stall_gati_end", 32'(Gati), 32'd0);
        Ndal = 1'b0;
        step();
        chk("stall_d0_done", 32'(d0), 32'h1234);
        chk("stall_num", 32'(Numri), 32'd2);

        // invalid select, then a valid one
        Valid = 1'b1; Hyrja = 16'hFFFF; S = 3'd6;
        step();
        Valid = 1'b0;
        step();
        chk("bad_gabim", 32'(Gabim), 32'd1);
        chk("bad_num", 32'(Numri), 32'd2);
        chk("bad_shk", 32'(Shkruar), 32'd0);
        chk("bad_d3", 32'(d3), 32'hA5A5);
        chk("bad_d0", 32'(d0), 32'h1234);
        Valid = 1'b1; Hyrja = 16'h5555; S = 3'd5;
        step();
        Valid = 1'b0;
        step();
        chk("after_bad_d5", 32'(d5), 32'h5555);
        chk("after_bad_gabim", 32'(Gabim), 32'd1);
        chk("after_bad_num", 32'(Numri), 32'd3);

        // wrap: 16 back-to-back writes; Valid stays high and the next
        // request is presented during the write cycle, which must be ignored
        do_reset();
        Valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            Hyrja = 16'h1000 + 16'(i);
            S     = 3'(i % 6);
            step();
            Hyrja = 16'hDEAD; S = 3'd7;
            step();
        end
        Valid = 1'b0;
        chk("wrap_num", 32'(Numri), 32'd0);
        chk("wrap_gabim", 32'(Gabim), 32'd0);
        chk("wrap_d0", 32'(d0), 32'h100C);
        chk("wrap_d1", 32'(d1), 32'h100D);
        chk("wrap_d2", 32'(d2), 32'h100E);
        chk("wrap_d3", 32'(d3), 32'h100F);
        chk("wrap_d4", 32'(d4), 32'h100A);
        chk("wrap_d5", 32'(d5), 32'h100B);

        // mid-write reset
        step();
        Valid = 1'b1; Hyrja = 16'hBEEF; S = 3'd2;
        step();
        Valid = 1'b0;
        Reset = 1'b1;
        #1;
        chk("midrst_shk", 32'(Shkruar), 32'd0);
        chk("midrst_gati", 32'(Gati), 32'd0);
        for (int k = 0; k < 6; k++) chk("midrst_dalja", 32'(dal[k]), 32'd0);
        step();
        chk("midrst_d2", 32'(d2), 32'd0);
        chk("midrst_shk2", 32'(Shkruar), 32'd0);
        Reset = 1'b0;
        #1;
        chk("midrst_init", 32'(Gati), 32'd0);
        step();
        chk("midrst_ready", 32'(Gati), 32'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/demux1ne6_sekuencial.md
DEMUX1NE6_SEKUENCIAL -- requirements
Module: demux1ne6_sekuencial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data word width.
REQ-002 The block SHALL have port Clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1, reset; asynchronous, active-high.
REQ-004 The block SHALL have port Hyrja, input, WIDTH, the data word to route.
REQ-005 The block SHALL have port S, input, 3, the destination select (0..5 valid, 6..7 invalid).
REQ-006 The block SHALL have port Valid, input, 1, meaning Hyrja/S carry a request.
REQ-007 The block SHALL have port Ndal, input, 1, a write stall request.
REQ-008 The block SHALL have port Gati, output, 1, ready; a request transfers when Valid=1 and Gati=1 at a rising edge.
REQ-009 The block SHALL have ports Dalja0..Dalja5, output, WIDTH each, registered destination words.
REQ-010 The block SHALL have port Shkruar, output, 6, one-hot write strobe; bit k is high for exactly one cycle when Dalja<k> is updated.
REQ-011 The block SHALL have port Gabim, output, 1, a sticky invalid-select flag.
REQ-012 The block SHALL have port Numri, output, 4, the count of completed writes.

Function
REQ-013 The FSM SHALL have states INIT, PRANIM (accept) and SHKRIM (write); Gati=1 only in PRANIM.
REQ-014 INIT SHALL go to PRANIM on the first rising edge after Reset deasserts, unconditionally.
REQ-015 In PRANIM with Valid=1, the block SHALL capture Hyrja and S into internal registers and go to SHKRIM on that edge.
REQ-016 In PRANIM with Valid=0, the block SHALL hold state and capture nothing.
REQ-017 In SHKRIM with Ndal=0 and captured S in 0..5, the block SHALL, on the edge, load the captured word into Dalja<S>, set Shkruar bit S for the following cycle, increment Numri, and go to PRANIM.
REQ-018 In SHKRIM with Ndal=1, the block SHALL hold all outputs and captured values, stay in SHKRIM, and keep Gati=0.
REQ-019 In SHKRIM with Ndal=0 and captured S = 6 or 7, the block SHALL leave all Dalja and Numri unchanged, keep Shkruar=0, set Gabim=1, and go to PRANIM.
REQ-020 Gabim SHALL stay 1 until Reset; a later valid write SHALL not clear it.
REQ-021 Latency SHALL be 2 edges from accept to Dalja update when Ndal=0; peak throughput SHALL be one request per 2 cycles.
REQ-022 Numri SHALL wrap from 15 to 0 with no flag.
REQ-023 Only the selected Dalja register SHALL change on a write; the other five SHALL hold.
REQ-024 Changes to Hyrja, S or Valid while in SHKRIM SHALL have no effect.
REQ-025 Shkruar SHALL be all-zero in every cycle except the one following a completed write.

Reset
REQ-026 While Reset=1, the block SHALL force state INIT, Gati=0, Dalja0..Dalja5=0, Shkruar=0, Gabim=0, Numri=0, and clear the captured registers, independent of Clock.
REQ-027 Reset asserted in SHKRIM SHALL abort the pending write; no Dalja update and no Shkruar pulse SHALL occur.

Verification
REQ-028 Bench SHALL check reset release: Reset 1->0 -> Gati=0 for one cycle, then Gati=1; all Dalja=0, Numri=0, Gabim=0.
REQ-029 Bench SHALL check basic routing: accept Hyrja=16'hA5A5, S=3, Ndal=0 -> two edges later Dalja3=16'hA5A5, Shkruar=6'b001000 for one cycle, Numri=1, other Dalja=0.
REQ-030 Bench SHALL check stall: accept Hyrja=16'h1234, S=0, hold Ndal=1 for 3 cycles -> Gati=0 and Dalja0=0 throughout; Ndal=0 -> Dalja0=16'h1234 on the next edge.
REQ-031 Bench SHALL check invalid select: accept S=6, Hyrja=16'hFFFF -> Gabim=1, all Dalja unchanged, Numri unchanged; a following S=5 write -> Dalja5 updated, Gabim still 1.
REQ-032 Bench SHALL check wrap: 16 back-to-back writes cycling S=0..5 -> Numri returns to 0, and each Dalja holds its last written word.
REQ-033 Bench SHALL check mid-write reset: assert Reset in SHKRIM -> Shkruar=0, all Dalja=0, state INIT.
